// File: rtl/mc_pkg.sv
// mc_pkg: shared state, ALU op, opcode/funct and datapath select encodings for the multicycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADDR, S_MEMRD, S_MEMWR,
    S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
  typedef enum logic [3:0] {
    C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
  } cls_t;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_SLT = 4'd4, ALU_ADDU = 4'd5, ALU_SUBU = 4'd6, ALU_PASS = 4'd7;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                         F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JT = 2'd2, PC_A = 2'd3;
  localparam logic [1:0] SB_B = 2'd0, SB_4 = 2'd1, SB_SE = 2'd2, SB_SE2 = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_31 = 2'd2;
  localparam logic [1:0] MR_ALU = 2'd0, MR_MDR = 2'd1, MR_PC = 2'd2;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: op/funct to instruction class, ALU operation, overflow-trap eligibility and legality
module mc_decode import mc_pkg::*; #(
  parameter int EN_JAL = 1
) (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] cls,
  output logic [3:0] alu_op,
  output logic       ovf_chk,
  output logic       legal
);
  always_comb begin
    cls = C_ILL;
    alu_op = ALU_PASS;
    ovf_chk = 1'b0;
    case (op)
      OP_R: case (funct)
        F_ADD:  begin cls = C_R; alu_op = ALU_ADD; ovf_chk = 1'b1; end
        F_ADDU: begin cls = C_R; alu_op = ALU_ADDU; end
        F_SUB:  begin cls = C_R; alu_op = ALU_SUB; ovf_chk = 1'b1; end
        F_SUBU: begin cls = C_R; alu_op = ALU_SUBU; end
        F_AND:  begin cls = C_R; alu_op = ALU_AND; end
        F_OR:   begin cls = C_R; alu_op = ALU_OR; end
        F_SLT:  begin cls = C_R; alu_op = ALU_SLT; end
        F_JR:   cls = C_JR;
        default: ;
      endcase
      OP_ADDI:  begin cls = C_I; alu_op = ALU_ADD; ovf_chk = 1'b1; end
      OP_ADDIU: begin cls = C_I; alu_op = ALU_ADDU; end
      OP_ANDI:  begin cls = C_I; alu_op = ALU_AND; end
      OP_ORI:   begin cls = C_I; alu_op = ALU_OR; end
      OP_SLTI:  begin cls = C_I; alu_op = ALU_SLT; end
      OP_LW:    cls = C_LW;
      OP_SW:    cls = C_SW;
      OP_BEQ:   cls = C_BEQ;
      OP_BNE:   cls = C_BNE;
      OP_J:     cls = C_J;
      OP_JAL:   cls = (EN_JAL != 0) ? C_JAL : C_ILL;
      default: ;
    endcase
  end
  assign legal = cls != C_ILL;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-style control FSM with memory wait timeout and sticky trap
module mc_ctrl import mc_pkg::*; #(
  parameter int MEM_TIMEOUT = 16,
  parameter int EN_OVF_TRAP = 1,
  parameter int EN_JAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_src,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [3:0] state,
  output logic       error
);
  localparam int CW = $clog2(MEM_TIMEOUT + 2);
  state_t cur, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] cls, dec_op;
  logic ovf_chk, legal, waiting, tmo, is_ovf;
  mc_decode #(.EN_JAL(EN_JAL)) u_dec (
    .op(op), .funct(funct), .cls(cls), .alu_op(dec_op), .ovf_chk(ovf_chk), .legal(legal)
  );
  // derived from state rather than mem_req to keep the output decode out of the timeout path
  assign waiting = (cur == S_FETCH || cur == S_MEMRD || cur == S_MEMWR) && !mem_ack;
  assign tmo = MEM_TIMEOUT != 0 && waiting && int'(cnt) == MEM_TIMEOUT - 1;
  assign is_ovf = EN_OVF_TRAP != 0 && alu_ovf && ovf_chk;
  assign state = cur;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur <= S_FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= (nxt != cur || !waiting) ? '0 : cnt + 1'b1;
    end
  always_comb begin
    nxt = cur;
    {mem_req, mem_we, mem_src, ir_we, mdr_we, pc_we, reg_we, alu_src_a, error} = '0;
    pc_src = PC_ALU;
    alu_src_b = SB_B;
    alu_op = ALU_ADD;
    reg_dst = RD_RT;
    mem_to_reg = MR_ALU;
    if (!reset) case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        alu_src_b = SB_4;
        ir_we = mem_ack;
        pc_we = mem_ack;
        nxt = mem_ack ? S_DECODE : tmo ? S_TRAP : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SB_SE2;
        nxt = !legal ? S_TRAP : cls == C_R ? S_EXEC_R : cls == C_I ? S_EXEC_I :
              (cls == C_LW || cls == C_SW) ? S_MEMADDR :
              (cls == C_BEQ || cls == C_BNE) ? S_BRANCH : S_JUMP;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op = dec_op;
        nxt = is_ovf ? S_TRAP : S_WB_R;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SB_SE;
        alu_op = dec_op;
        nxt = is_ovf ? S_TRAP : S_WB_I;
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SB_SE;
        nxt = cls == C_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        mem_src = 1'b1;
        mdr_we = mem_ack;
        nxt = mem_ack ? S_WB_MEM : tmo ? S_TRAP : S_MEMRD;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_src = 1'b1;
        nxt = mem_ack ? S_FETCH : tmo ? S_TRAP : S_MEMWR;
      end
      S_WB_R: begin
        reg_we = 1'b1;
        reg_dst = RD_RD;
        nxt = S_FETCH;
      end
      S_WB_I: begin
        reg_we = 1'b1;
        nxt = S_FETCH;
      end
      S_WB_MEM: begin
        reg_we = 1'b1;
        mem_to_reg = MR_MDR;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALU_SUB;
        pc_src = PC_ALUOUT;
        pc_we = cls == C_BNE ? !alu_zero : alu_zero;
        nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_we = 1'b1;
        pc_src = cls == C_JR ? PC_A : PC_JT;
        reg_we = cls == C_JAL;
        reg_dst = cls == C_JAL ? RD_31 : RD_RT;
        mem_to_reg = cls == C_JAL ? MR_PC : MR_ALU;
        nxt = S_FETCH;
      end
      S_TRAP: error = 1'b1;
      default: nxt = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed checks of mc_ctrl; dut_a uses MEM_TIMEOUT=4 with traps enabled, dut_b disables timeout, overflow trap and jal
module tb_mc_ctrl;
  logic clk = 1'b0, reset = 1'b1, alu_zero = 1'b0, alu_ovf = 1'b0, mem_ack = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic a_mem_req, a_mem_we, a_mem_src, a_ir_we, a_mdr_we, a_pc_we, a_reg_we, a_alu_src_a, a_error;
  logic [1:0] a_pc_src, a_alu_src_b, a_reg_dst, a_mem_to_reg;
  logic [3:0] a_alu_op, a_state;
  logic b_mem_req, b_mem_we, b_mem_src, b_ir_we, b_mdr_we, b_pc_we, b_reg_we, b_alu_src_a, b_error;
  logic [1:0] b_pc_src, b_alu_src_b, b_reg_dst, b_mem_to_reg;
  logic [3:0] b_alu_op, b_state;
  logic [5:0] a_en;
  logic [24:0] a_all;
  int total = 0, passed = 0;

  always #5 clk = ~clk;
  assign a_en = {a_mem_req, a_mem_we, a_ir_we, a_mdr_we, a_pc_we, a_reg_we};
  assign a_all = {a_en, a_mem_src, a_alu_src_a, a_error, a_pc_src, a_alu_src_b, a_reg_dst,
                  a_mem_to_reg, a_alu_op, a_state};

  mc_ctrl #(.MEM_TIMEOUT(4), .EN_OVF_TRAP(1), .EN_JAL(1)) dut_a (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .mem_ack(mem_ack), .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_src(a_mem_src),
    .ir_we(a_ir_we), .mdr_we(a_mdr_we), .pc_we(a_pc_we), .reg_we(a_reg_we), .pc_src(a_pc_src),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .reg_dst(a_reg_dst),
    .mem_to_reg(a_mem_to_reg), .state(a_state), .error(a_error));
  mc_ctrl #(.MEM_TIMEOUT(0), .EN_OVF_TRAP(0), .EN_JAL(0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .mem_ack(mem_ack), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_src(b_mem_src),
    .ir_we(b_ir_we), .mdr_we(b_mdr_we), .pc_we(b_pc_we), .reg_we(b_reg_we), .pc_src(b_pc_src),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .reg_dst(b_reg_dst),
    .mem_to_reg(b_mem_to_reg), .state(b_state), .error(b_error));

  task automatic cyc(input logic ack, input logic zero, input logic ovf);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = ack;
    alu_zero = zero;
    alu_ovf = ovf;
    #1;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b0;
    alu_zero = 1'b0;
    alu_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    mem_ack = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (a_all !== 25'd0) $display("FAIL reset_outputs got=%h exp=0", a_all); else passed++;
    total++;
    if ({b_mem_req, b_ir_we, b_state} !== 6'd0) $display("FAIL reset_b got=%h exp=0", {b_mem_req, b_ir_we, b_state}); else passed++;
  endtask

  task automatic test_add();
    logic [6:0] e [5];
    e = '{{4'd0, 3'd0}, {4'd1, 3'd0}, {4'd2, 3'd0}, {4'd7, 1'b1, 2'd1}, {4'd0, 3'd0}};
    hold_reset();
    op = 6'h00;
    funct = 6'h20;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      total++;
      if ({a_state, a_reg_we, a_reg_dst} !== e[i])
        $display("FAIL add_c%0d got=%h exp=%h", i, {a_state, a_reg_we, a_reg_dst}, e[i]);
      else passed++;
      if (i == 0) begin
        total++;
        if ({a_mem_req, a_ir_we, a_pc_we, a_alu_src_b, a_mem_src} !== 6'b111010)
          $display("FAIL add_fetch got=%b exp=111010", {a_mem_req, a_ir_we, a_pc_we, a_alu_src_b, a_mem_src});
        else passed++;
      end
      if (i == 1) begin
        total++;
        if ({a_alu_src_a, a_alu_src_b} !== 3'b011) $display("FAIL add_decode got=%b exp=011", {a_alu_src_a, a_alu_src_b}); else passed++;
      end
      if (i == 2) begin
        total++;
        if ({a_alu_src_a, a_alu_src_b, a_alu_op} !== 7'b1000000) $display("FAIL add_exec got=%b exp=1000000", {a_alu_src_a, a_alu_src_b, a_alu_op}); else passed++;
      end
    end
  endtask

  task automatic test_lw();
    logic [6:0] e [9];
    logic ack [9];
    e = '{{4'd0, 3'b100}, {4'd1, 3'b000}, {4'd4, 3'b000}, {4'd5, 3'b100}, {4'd5, 3'b100},
          {4'd5, 3'b100}, {4'd5, 3'b110}, {4'd9, 3'b001}, {4'd0, 3'b100}};
    ack = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    hold_reset();
    op = 6'h23;
    for (int i = 0; i < 9; i++) begin
      cyc(ack[i], 1'b0, 1'b0);
      total++;
      if ({a_state, a_mem_req, a_mdr_we, a_reg_we} !== e[i])
        $display("FAIL lw_c%0d got=%h exp=%h", i, {a_state, a_mem_req, a_mdr_we, a_reg_we}, e[i]);
      else passed++;
      if (i == 3) begin
        total++;
        if ({a_mem_src, a_mem_we} !== 2'b10) $display("FAIL lw_memrd_src got=%b exp=10", {a_mem_src, a_mem_we}); else passed++;
      end
      if (i == 7) begin
        total++;
        if ({a_mem_to_reg, a_reg_dst} !== 4'b0100) $display("FAIL lw_wb got=%b exp=0100", {a_mem_to_reg, a_reg_dst}); else passed++;
      end
    end
  endtask

  task automatic test_sw();
    logic [3:0] s [5];
    s = '{4'd0, 4'd1, 4'd4, 4'd6, 4'd0};
    hold_reset();
    op = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      total++;
      if (a_state !== s[i]) $display("FAIL sw_c%0d got=%0d exp=%0d", i, a_state, s[i]); else passed++;
      if (i == 3) begin
        total++;
        if ({a_mem_req, a_mem_we, a_mem_src, a_reg_we} !== 4'b1110) $display("FAIL sw_memwr got=%b exp=1110", {a_mem_req, a_mem_we, a_mem_src, a_reg_we}); else passed++;
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [4];
    logic z [4];
    logic pw [4];
    ops = '{6'h04, 6'h05, 6'h04, 6'h05};
    z = '{1'b1, 1'b1, 1'b0, 1'b0};
    pw = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      hold_reset();
      op = ops[k];
      for (int i = 0; i < 3; i++) cyc(1'b1, z[k], 1'b0);
      total++;
      if ({a_state, a_pc_we, a_pc_src, a_alu_op, a_alu_src_a, a_reg_we} !== {4'd10, pw[k], 2'd1, 4'd1, 1'b1, 1'b0})
        $display("FAIL branch_%0d got=%h exp=%h", k, {a_state, a_pc_we, a_pc_src, a_alu_op, a_alu_src_a, a_reg_we},
                 {4'd10, pw[k], 2'd1, 4'd1, 1'b1, 1'b0});
      else passed++;
      cyc(1'b1, z[k], 1'b0);
      total++;
      if (a_state !== 4'd0) $display("FAIL branch_ret_%0d got=%0d exp=0", k, a_state); else passed++;
    end
  endtask

  task automatic test_jump();
    hold_reset();
    op = 6'h03;
    funct = 6'h00;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    total++;
    if ({a_state, a_reg_we, a_reg_dst, a_mem_to_reg, a_pc_src, a_pc_we} !== {4'd11, 1'b1, 2'd2, 2'd2, 2'd2, 1'b1})
      $display("FAIL jal_a got=%h exp=%h", {a_state, a_reg_we, a_reg_dst, a_mem_to_reg, a_pc_src, a_pc_we}, {4'd11, 1'b1, 2'd2, 2'd2, 2'd2, 1'b1});
    else passed++;
    total++;
    if ({b_state, b_error, b_reg_we, b_pc_we} !== {4'd12, 3'b100}) $display("FAIL jal_b_trap got=%h exp=%h", {b_state, b_error, b_reg_we, b_pc_we}, {4'd12, 3'b100}); else passed++;
    hold_reset();
    op = 6'h00;
    funct = 6'h08;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    total++;
    if ({a_state, a_pc_src, a_pc_we, a_reg_we} !== {4'd11, 2'd3, 2'b10}) $display("FAIL jr got=%h exp=%h", {a_state, a_pc_src, a_pc_we, a_reg_we}, {4'd11, 2'd3, 2'b10}); else passed++;
    hold_reset();
    op = 6'h02;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i == 2) begin
        total++;
        if ({a_state, a_pc_src, a_pc_we, a_reg_we} !== {4'd11, 2'd2, 2'b10}) $display("FAIL j got=%h exp=%h", {a_state, a_pc_src, a_pc_we, a_reg_we}, {4'd11, 2'd2, 2'b10}); else passed++;
      end
    end
    total++;
    if (a_state !== 4'd0) $display("FAIL j_ret got=%0d exp=0", a_state); else passed++;
  endtask

  task automatic test_illegal();
    hold_reset();
    op = 6'h3F;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    total++;
    if (a_state !== 4'd1) $display("FAIL ill_decode got=%0d exp=1", a_state); else passed++;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      total++;
      if ({a_state, a_error, a_en} !== {4'd12, 1'b1, 6'd0}) $display("FAIL ill_trap_%0d got=%h exp=%h", i, {a_state, a_error, a_en}, {4'd12, 1'b1, 6'd0}); else passed++;
    end
    hold_reset();
    op = 6'h00;
    funct = 6'h00;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    total++;
    if ({a_state, a_error} !== {4'd12, 1'b1}) $display("FAIL ill_funct got=%h exp=%h", {a_state, a_error}, {4'd12, 1'b1}); else passed++;
  endtask

  task automatic test_ovf();
    hold_reset();
    op = 6'h08;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    total++;
    if ({a_state, b_state, a_alu_src_b} !== {4'd3, 4'd3, 2'd2}) $display("FAIL addi_exec got=%h exp=%h", {a_state, b_state, a_alu_src_b}, {4'd3, 4'd3, 2'd2}); else passed++;
    cyc(1'b1, 1'b0, 1'b0);
    total++;
    if ({a_state, a_reg_we, a_error} !== {4'd12, 2'b01}) $display("FAIL addi_ovf_a got=%h exp=%h", {a_state, a_reg_we, a_error}, {4'd12, 2'b01}); else passed++;
    total++;
    if ({b_state, b_reg_we, b_reg_dst, b_error} !== {4'd8, 1'b1, 2'd0, 1'b0}) $display("FAIL addi_ovf_b got=%h exp=%h", {b_state, b_reg_we, b_reg_dst, b_error}, {4'd8, 1'b1, 2'd0, 1'b0}); else passed++;
    hold_reset();
    op = 6'h09;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    total++;
    if ({a_state, a_reg_we} !== {4'd8, 1'b1}) $display("FAIL addiu_ovf got=%h exp=%h", {a_state, a_reg_we}, {4'd8, 1'b1}); else passed++;
  endtask

  task automatic test_timeout();
    hold_reset();
    op = 6'h00;
    funct = 6'h20;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      total++;
      if ({a_state, a_mem_req, a_ir_we} !== {4'd0, 2'b10}) $display("FAIL tmo_wait_%0d got=%h exp=%h", i, {a_state, a_mem_req, a_ir_we}, {4'd0, 2'b10}); else passed++;
    end
    cyc(1'b1, 1'b0, 1'b0);
    total++;
    if ({a_state, a_error, a_en} !== {4'd12, 1'b1, 6'd0}) $display("FAIL tmo_trap got=%h exp=%h", {a_state, a_error, a_en}, {4'd12, 1'b1, 6'd0}); else passed++;
    total++;
    if ({b_state, b_mem_req} !== {4'd0, 1'b1}) $display("FAIL tmo_disabled got=%h exp=%h", {b_state, b_mem_req}, {4'd0, 1'b1}); else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({a_state, a_error} !== 5'd0) $display("FAIL tmo_reset got=%h exp=0", {a_state, a_error}); else passed++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    total++;
    if ({a_state, a_ir_we} !== {4'd0, 1'b1}) $display("FAIL tmo_ack_limit got=%h exp=%h", {a_state, a_ir_we}, {4'd0, 1'b1}); else passed++;
    cyc(1'b1, 1'b0, 1'b0);
    total++;
    if ({a_state, a_error} !== {4'd1, 1'b0}) $display("FAIL tmo_ack_wins got=%h exp=%h", {a_state, a_error}, {4'd1, 1'b0}); else passed++;
  endtask

  task automatic test_async_reset();
    hold_reset();
    op = 6'h23;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    total++;
    if (a_state !== 4'd4) $display("FAIL ar_pre got=%0d exp=4", a_state); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (a_all !== 25'd0) $display("FAIL ar_mid got=%h exp=0", a_all); else passed++;
    cyc(1'b1, 1'b0, 1'b0);
    total++;
    if ({a_state, a_mem_req, a_ir_we} !== {4'd0, 2'b11}) $display("FAIL ar_first_fetch got=%h exp=%h", {a_state, a_mem_req, a_ir_we}, {4'd0, 2'b11}); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_illegal();
    test_ovf();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
